spram_arbiter: RTL and testbench
================================

// Module: spram_arbiter
// PURPOSE
//   Shares one SB_SPRAM256KA (16K x 16) between two requesters using round-robin arbitration.
//   Each port has a valid/ready handshake: reads return one response, writes are fire-and-forget.
//   After a programmable idle time it places the SPRAM in STANDBY; the next request wakes it.
//   Sits between the ESTU memory clients and the SPRAM primitive (or its simulation model).
// PARAMETERS
//   IDLE_CYCLES  16  consecutive idle cycles before entering STANDBY; 0 = never enter STANDBY
//   WAKE_CYCLES  2   cycles the block waits after deasserting STANDBY before accepting requests (>=1)
// PORTS
//   clk            in   1   single clock; also drives ram CLOCK
//   rst            in   1   synchronous, active-high reset
//   req_valid_0/1  in   1   port n request valid; addr/we/wdata/mask held stable until ready
//   req_ready_0/1  out  1   port n request accepted this cycle (when valid&ready)
//   req_we_0/1     in   1   1 = write, 0 = read
//   req_addr_0/1   in   14  word address
//   req_wdata_0/1  in   16  write data
//   req_mask_0/1   in   4   nibble write enables, maps to MASKWREN
//   rsp_valid_0/1  out  1   read data valid on port n (single-cycle pulse)
//   rsp_rdata_0/1  out  16  read data; qualified by rsp_valid_n
//   ram_addr       out  14  to ADDRESS
//   ram_datain     out  16  to DATAIN
//   ram_maskwren   out  4   to MASKWREN
//   ram_wren       out  1   to WREN
//   ram_cs         out  1   to CHIPSELECT
//   ram_standby    out  1   to STANDBY
//   ram_sleep      out  1   to SLEEP; constant 0
//   ram_poweroff   out  1   to POWEROFF; constant 1 (active-low, power stays on)
//   ram_dataout    in   16  from DATAOUT
//   lp_state       out  1   1 while ram_standby is asserted or the wake countdown is running
// BEHAVIOUR
// - States: ACTIVE, STANDBY, WAKE.
// - Reset values: state = ACTIVE, rr pointer = port 0, idle count = 0, ram_standby = 0,
//   rsp_valid_n = 0, rsp_rdata_n = 0, and the wake count is cleared.
// - ACTIVE:
//   - Grant is combinational from the valids.
//   - If only one port is valid, that port is granted.
//   - If both are valid, the port selected by the rr pointer is granted; the pointer then moves to
//     the other port. The pointer changes only on a grant.
//   - req_ready_n = grant_n. No ready is given in STANDBY or WAKE.
// - RAM drive:
//   - On an accepted request, ram_cs = 1 and ram_addr/datain/maskwren/wren come from the granted port
//     in the same cycle; the SPRAM captures them on the next posedge.
//   - With no grant: ram_cs = 0, and addr, datain, maskwren and wren are all 0.
// - Read latency: a read accepted in cycle t gives rsp_valid_n = 1 in cycle t+1, with
//   rsp_rdata_n = ram_dataout.
//   - rsp_rdata_n holds its last value otherwise.
//   - Back-to-back reads give one response per cycle, in order.
// - Writes produce no response. A mask of 0 is still accepted (cs=1, wren=1) and the memory is unchanged.
// - Idle count: increments in ACTIVE when neither valid is high and no response is pending.
//   Any valid, or a pending response, clears it.
// - Entering STANDBY: when the count reaches IDLE_CYCLES and no valid is present, state -> STANDBY
//   and ram_standby = 1 from the next cycle. If a valid arrives in the threshold cycle, the request
//   is served and the state stays ACTIVE.
// - STANDBY: any valid moves to WAKE. ram_standby is 0 from the WAKE cycle onward, and the wake
//   count is loaded with WAKE_CYCLES.
// - WAKE: the count decrements each cycle; at 0 the state returns to ACTIVE. Requests stay pending
//   and the first grant follows normal round-robin. Dropped valids in WAKE do not abort the wake.
// - Reset mid-operation:
//   - The pending response is discarded and rsp_valid is 0 the next cycle.
//   - A request presented during the reset cycle is not accepted (ready = 0 while rst).
//   - Reset during STANDBY/WAKE returns to ACTIVE with standby deasserted.
// - Protocol: the requester must keep valid high until ready. The block never reorders requests
//   within a port.
// TESTING
// - Single read/write: after reset, port0 writes 0xBEEF to 0x0123 (mask F), then reads 0x0123
//   -> rsp_valid_0 one cycle after accept, rdata 0xBEEF.
// - Contention: both ports read every cycle for 8 cycles -> grants alternate 0,1,0,1...;
//   each port gets 4 responses in order.
// - Nibble mask: write 0x1234 (mask F), then 0xABCD with mask 0101b; read
//   -> 0x1B3D.
// - Power: 16 idle cycles -> ram_standby = 1 and lp_state = 1; port1 then raises valid
//   -> ready after 1 STANDBY cycle plus 2 WAKE cycles, and data is intact.
// - Threshold collision: valid arrives exactly in the cycle the idle count hits 16
//   -> accepted immediately, no standby pulse.
// - Reset mid-read: assert rst in the cycle after a read accept -> no rsp_valid; all outputs at
//   their reset values next cycle.

Source files
------------

// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one SB_SPRAM256KA between two valid/ready requesters,
// with idle-driven STANDBY entry and a timed wake-up before service resumes.
module spram_arbiter #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic        req_we_0,
  input  logic [13:0] req_addr_0,
  input  logic [15:0] req_wdata_0,
  input  logic [3:0]  req_mask_0,
  output logic        rsp_valid_0,
  output logic [15:0] rsp_rdata_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic        req_we_1,
  input  logic [13:0] req_addr_1,
  input  logic [15:0] req_wdata_1,
  input  logic [3:0]  req_mask_1,
  output logic        rsp_valid_1,
  output logic [15:0] rsp_rdata_1,
  output logic [13:0] ram_addr,
  output logic [15:0] ram_datain,
  output logic [3:0]  ram_maskwren,
  output logic        ram_wren,
  output logic        ram_cs,
  output logic        ram_standby,
  output logic        ram_sleep,
  output logic        ram_poweroff,
  input  logic [15:0] ram_dataout,
  output logic        lp_state
);

  typedef enum logic [1:0] {ACTIVE, STANDBY, WAKE} state_e;

  localparam logic [15:0] IDLE_LIMIT = 16'(IDLE_CYCLES);
  localparam logic [15:0] WAKE_INIT  = 16'(WAKE_CYCLES);

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic [15:0] idle_q, idle_d;
  logic [15:0] wake_q, wake_d;
  logic [1:0]  pend_q, pend_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic        gnt_0, gnt_1, any_valid;

  assign any_valid = req_valid_0 | req_valid_1;

  // rr_q names the port that wins the next tie; it flips away from whoever was just granted.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (state_q == ACTIVE && !rst) begin
      if (req_valid_0 && (!req_valid_1 || !rr_q)) begin
        gnt_0 = 1'b1;
      end else if (req_valid_1) begin
        gnt_1 = 1'b1;
      end
    end
    rr_d = rr_q;
    if (gnt_0) begin
      rr_d = 1'b1;
    end else if (gnt_1) begin
      rr_d = 1'b0;
    end
    pend_d = {gnt_1 & ~req_we_1, gnt_0 & ~req_we_0};
  end

  always_comb begin
    req_ready_0  = gnt_0;
    req_ready_1  = gnt_1;
    ram_cs       = gnt_0 | gnt_1;
    ram_addr     = '0;
    ram_datain   = '0;
    ram_maskwren = '0;
    ram_wren     = 1'b0;
    if (gnt_0) begin
      ram_addr     = req_addr_0;
      ram_datain   = req_wdata_0;
      ram_maskwren = req_mask_0;
      ram_wren     = req_we_0;
    end else if (gnt_1) begin
      ram_addr     = req_addr_1;
      ram_datain   = req_wdata_1;
      ram_maskwren = req_mask_1;
      ram_wren     = req_we_1;
    end
    ram_standby  = (state_q == STANDBY);
    ram_sleep    = 1'b0;
    ram_poweroff = 1'b1;
    lp_state     = (state_q != ACTIVE);
  end

  // The SPRAM presents read data the cycle after capture, so it is forwarded straight through.
  always_comb begin
    rsp_valid_0 = pend_q[0] & ~rst;
    rsp_valid_1 = pend_q[1] & ~rst;
    rdata0_d    = rsp_valid_0 ? ram_dataout : rdata0_q;
    rdata1_d    = rsp_valid_1 ? ram_dataout : rdata1_q;
    rsp_rdata_0 = rdata0_d;
    rsp_rdata_1 = rdata1_d;
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    case (state_q)
      ACTIVE: begin
        if (any_valid || pend_q != 2'b00) begin
          idle_d = '0;
        end else if (IDLE_CYCLES != 0 && idle_q == IDLE_LIMIT) begin
          state_d = STANDBY;
          idle_d  = '0;
        end else if (idle_q != IDLE_LIMIT) begin
          idle_d = idle_q + 16'd1;
        end
      end
      STANDBY: begin
        if (any_valid) begin
          state_d = WAKE;
          wake_d  = WAKE_INIT;
        end
      end
      WAKE: begin
        if (wake_q <= 16'd1) begin
          wake_d  = '0;
          state_d = ACTIVE;
        end else begin
          wake_d = wake_q - 16'd1;
        end
      end
      default: begin
        state_d = ACTIVE;
        wake_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACTIVE;
      rr_q     <= 1'b0;
      idle_q   <= '0;
      wake_q   <= '0;
      pend_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      idle_q   <= idle_d;
      wake_q   <= wake_d;
      pend_q   <= pend_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of arbitration and memory contents.
module tb_spram_arbiter;

  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_0, req_ready_0, req_we_0;
  logic [13:0] req_addr_0;
  logic [15:0] req_wdata_0;
  logic [3:0]  req_mask_0;
  logic        rsp_valid_0;
  logic [15:0] rsp_rdata_0;
  logic        req_valid_1, req_ready_1, req_we_1;
  logic [13:0] req_addr_1;
  logic [15:0] req_wdata_1;
  logic [3:0]  req_mask_1;
  logic        rsp_valid_1;
  logic [15:0] rsp_rdata_1;
  logic [13:0] ram_addr;
  logic [15:0] ram_datain;
  logic [3:0]  ram_maskwren;
  logic        ram_wren, ram_cs, ram_standby, ram_sleep, ram_poweroff;
  logic [15:0] ram_dataout;
  logic        lp_state;

  int errors = 0;
  int checks = 0;
  int exp_rr = 0;

  logic [15:0] sram    [0:16383];
  logic [15:0] ref_mem [0:16383];

  spram_arbiter #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
    .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0), .req_mask_0(req_mask_0),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
    .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1), .req_mask_1(req_mask_1),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
    .ram_addr(ram_addr), .ram_datain(ram_datain), .ram_maskwren(ram_maskwren),
    .ram_wren(ram_wren), .ram_cs(ram_cs), .ram_standby(ram_standby),
    .ram_sleep(ram_sleep), .ram_poweroff(ram_poweroff),
    .ram_dataout(ram_dataout), .lp_state(lp_state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] merge_mask(input logic [15:0] old_w, input logic [15:0] new_w,
                                             input logic [3:0] m);
    logic [15:0] bm;
    for (int n = 0; n < 4; n++) bm[n*4 +: 4] = {4{m[n]}};
    return (old_w & ~bm) | (new_w & bm);
  endfunction

  // Behavioural SPRAM: captures on posedge, read data appears the following cycle.
  always @(posedge clk) begin
    if (ram_cs === 1'b1) begin
      if (ram_wren) sram[ram_addr] <= merge_mask(sram[ram_addr], ram_datain, ram_maskwren);
      else ram_dataout <= sram[ram_addr];
    end
  end

  task automatic idle_inputs;
    req_valid_0 = 1'b0; req_we_0 = 1'b0; req_addr_0 = '0; req_wdata_0 = '0; req_mask_0 = '0;
    req_valid_1 = 1'b0; req_we_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0; req_mask_1 = '0;
  endtask

  task automatic reset_dut;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_rr = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1; req_valid_0 = 1'b1; req_addr_0 = 14'h0005;
    #1;
    checks++; if (req_ready_0 !== 1'b0) begin errors++; $display("[TB] FAIL reset ready_0: got %b expected 0", req_ready_0); end
    checks++; if (ram_cs !== 1'b0) begin errors++; $display("[TB] FAIL reset ram_cs: got %b expected 0", ram_cs); end
    @(negedge clk);
    #1;
    checks++; if (req_ready_0 !== 1'b0) begin errors++; $display("[TB] FAIL reset ready_0 held: got %b expected 0", req_ready_0); end
    @(negedge clk);
    rst = 1'b0; req_valid_0 = 1'b0;
    #1;
    checks++; if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0) begin errors++; $display("[TB] FAIL reset rsp_valid: got %b%b expected 00", rsp_valid_1, rsp_valid_0); end
    checks++; if (rsp_rdata_0 !== 16'h0 || rsp_rdata_1 !== 16'h0) begin errors++; $display("[TB] FAIL reset rsp_rdata: got %h/%h expected 0000/0000", rsp_rdata_0, rsp_rdata_1); end
    checks++; if (ram_standby !== 1'b0 || lp_state !== 1'b0) begin errors++; $display("[TB] FAIL reset power: got standby=%b lp=%b expected 0/0", ram_standby, lp_state); end
    checks++; if (ram_sleep !== 1'b0 || ram_poweroff !== 1'b1) begin errors++; $display("[TB] FAIL reset sleep/poweroff: got %b/%b expected 0/1", ram_sleep, ram_poweroff); end
    checks++; if (ram_cs !== 1'b0 || ram_addr !== 14'h0) begin errors++; $display("[TB] FAIL reset ram idle: got cs=%b addr=%h expected 0/0000", ram_cs, ram_addr); end
    // Pointer starts at port 0, so the first tie goes to port 0.
    @(negedge clk);
    req_valid_0 = 1'b1; req_valid_1 = 1'b1; req_addr_0 = 14'h0005; req_addr_1 = 14'h0006;
    #1;
    checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin errors++; $display("[TB] FAIL reset rr start: got ready=%b%b expected 01", req_ready_1, req_ready_0); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rsp_valid_0 !== 1'b1) begin errors++; $display("[TB] FAIL reset first rsp: got %b expected 1", rsp_valid_0); end
  endtask

  task automatic test_single_rw;
    reset_dut();
    @(negedge clk);
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 14'h0123; req_wdata_0 = 16'hBEEF; req_mask_0 = 4'hF;
    #1;
    checks++; if (req_ready_0 !== 1'b1) begin errors++; $display("[TB] FAIL rw write ready: got %b expected 1", req_ready_0); end
    checks++; if ({ram_cs, ram_wren, ram_maskwren} !== 6'b11_1111) begin errors++; $display("[TB] FAIL rw write ctrl: got cs=%b wren=%b mask=%h expected 1/1/f", ram_cs, ram_wren, ram_maskwren); end
    checks++; if (ram_addr !== 14'h0123 || ram_datain !== 16'hBEEF) begin errors++; $display("[TB] FAIL rw write bus: got %h/%h expected 0123/beef", ram_addr, ram_datain); end
    @(negedge clk);
    req_we_0 = 1'b0;
    #1;
    checks++; if (req_ready_0 !== 1'b1 || ram_wren !== 1'b0) begin errors++; $display("[TB] FAIL rw read accept: got ready=%b wren=%b expected 1/0", req_ready_0, ram_wren); end
    checks++; if (rsp_valid_0 !== 1'b0) begin errors++; $display("[TB] FAIL rw write no rsp: got %b expected 0", rsp_valid_0); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rsp_valid_0 !== 1'b1 || rsp_valid_1 !== 1'b0) begin errors++; $display("[TB] FAIL rw rsp_valid: got %b%b expected 01", rsp_valid_1, rsp_valid_0); end
    checks++; if (rsp_rdata_0 !== 16'hBEEF) begin errors++; $display("[TB] FAIL rw rdata: got %h expected beef", rsp_rdata_0); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid_0 !== 1'b0 || rsp_rdata_0 !== 16'hBEEF) begin errors++; $display("[TB] FAIL rw rdata hold: got v=%b d=%h expected 0/beef", rsp_valid_0, rsp_rdata_0); end
  endtask

  task automatic test_mask;
    logic [15:0] wd [3];
    logic [3:0]  wm [3];
    wd = '{16'h1234, 16'hABCD, 16'hFFFF};
    wm = '{4'hF, 4'b0101, 4'h0};
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid_1 = 1'b1; req_we_1 = 1'b1; req_addr_1 = 14'h0456; req_wdata_1 = wd[k]; req_mask_1 = wm[k];
      #1;
      checks++; if (req_ready_1 !== 1'b1 || ram_cs !== 1'b1 || ram_wren !== 1'b1 || ram_maskwren !== wm[k]) begin
        errors++; $display("[TB] FAIL mask write %0d: got ready=%b cs=%b wren=%b mask=%h expected 1/1/1/%h", k, req_ready_1, ram_cs, ram_wren, ram_maskwren, wm[k]);
      end
    end
    @(negedge clk);
    req_we_1 = 1'b0;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rsp_valid_1 !== 1'b1 || rsp_rdata_1 !== 16'h1B3D) begin errors++; $display("[TB] FAIL mask readback: got v=%b d=%h expected 1/1b3d", rsp_valid_1, rsp_rdata_1); end
  endtask

  task automatic test_contention;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] wd [2][4];
    logic [15:0] e;
    int idx [2];
    int got [2];
    int g;
    reset_dut();
    for (int p = 0; p < 2; p++) for (int k = 0; k < 4; k++) wd[p][k] = 16'($urandom);
    for (int ph = 0; ph < 2; ph++) begin
      idx[0] = 0; idx[1] = 0; got[0] = 0; got[1] = 0;
      for (int c = 0; c < 9; c++) begin
        @(negedge clk);
        req_valid_0 = (idx[0] < 4); req_we_0 = (ph == 0); req_addr_0 = 14'h1000 + 14'(idx[0]);
        req_wdata_0 = wd[0][idx[0] & 3]; req_mask_0 = 4'hF;
        req_valid_1 = (idx[1] < 4); req_we_1 = (ph == 0); req_addr_1 = 14'h1010 + 14'(idx[1]);
        req_wdata_1 = wd[1][idx[1] & 3]; req_mask_1 = 4'hF;
        #1;
        g = -1;
        if (req_valid_0 && req_valid_1) g = exp_rr;
        else if (req_valid_0) g = 0;
        else if (req_valid_1) g = 1;
        checks++; if (req_ready_0 !== (g == 0) || req_ready_1 !== (g == 1)) begin
          errors++; $display("[TB] FAIL contention grant ph%0d c%0d: got ready=%b%b expected port %0d", ph, c, req_ready_1, req_ready_0, g);
        end
        if (rsp_valid_0 === 1'b1) begin
          got[0]++;
          e = (q0.size() > 0) ? q0.pop_front() : 16'h0;
          checks++; if (rsp_rdata_0 !== e) begin errors++; $display("[TB] FAIL contention rdata_0: got %h expected %h", rsp_rdata_0, e); end
        end
        if (rsp_valid_1 === 1'b1) begin
          got[1]++;
          e = (q1.size() > 0) ? q1.pop_front() : 16'h0;
          checks++; if (rsp_rdata_1 !== e) begin errors++; $display("[TB] FAIL contention rdata_1: got %h expected %h", rsp_rdata_1, e); end
        end
        if (g == 0) begin
          if (ph == 0) ref_mem[req_addr_0] = req_wdata_0; else q0.push_back(ref_mem[req_addr_0]);
          idx[0]++; exp_rr = 1;
        end else if (g == 1) begin
          if (ph == 0) ref_mem[req_addr_1] = req_wdata_1; else q1.push_back(ref_mem[req_addr_1]);
          idx[1]++; exp_rr = 0;
        end
      end
      checks++; if (got[0] != ph * 4 || got[1] != ph * 4) begin
        errors++; $display("[TB] FAIL contention rsp count ph%0d: got %0d/%0d expected %0d/%0d", ph, got[0], got[1], ph * 4, ph * 4);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random;
    logic        pv [2];
    logic        pwe [2];
    logic [13:0] pa [2];
    logic [15:0] pd [2];
    logic [3:0]  pm [2];
    logic [15:0] rsp_data;
    int g, rsp_port;
    reset_dut();
    pv[0] = 1'b0; pv[1] = 1'b0; rsp_port = -1; rsp_data = '0;
    for (int c = 0; c < 301; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (c < 300 && !pv[p] && ($urandom_range(0, 9) < 6 || (p == 0 && c % 10 == 0))) begin
          pv[p] = 1'b1; pwe[p] = 1'($urandom_range(0, 1));
          pa[p] = 14'h3000 + 14'($urandom_range(0, 15));
          pd[p] = 16'($urandom); pm[p] = 4'($urandom);
        end
      end
      @(negedge clk);
      req_valid_0 = pv[0]; req_we_0 = pwe[0]; req_addr_0 = pa[0]; req_wdata_0 = pd[0]; req_mask_0 = pm[0];
      req_valid_1 = pv[1]; req_we_1 = pwe[1]; req_addr_1 = pa[1]; req_wdata_1 = pd[1]; req_mask_1 = pm[1];
      #1;
      g = -1;
      if (pv[0] && pv[1]) g = exp_rr;
      else if (pv[0]) g = 0;
      else if (pv[1]) g = 1;
      checks++; if (req_ready_0 !== (g == 0) || req_ready_1 !== (g == 1)) begin
        errors++; $display("[TB] FAIL random grant c%0d: got ready=%b%b expected port %0d", c, req_ready_1, req_ready_0, g);
      end
      checks++; if (ram_cs !== (g >= 0) || (g >= 0 && ram_addr !== pa[g])) begin
        errors++; $display("[TB] FAIL random ram bus c%0d: got cs=%b addr=%h expected port %0d", c, ram_cs, ram_addr, g);
      end
      checks++; if (rsp_valid_0 !== (rsp_port == 0) || rsp_valid_1 !== (rsp_port == 1)) begin
        errors++; $display("[TB] FAIL random rsp_valid c%0d: got %b%b expected port %0d", c, rsp_valid_1, rsp_valid_0, rsp_port);
      end
      if (rsp_port >= 0) begin
        checks++; if ((rsp_port == 0 ? rsp_rdata_0 : rsp_rdata_1) !== rsp_data) begin
          errors++; $display("[TB] FAIL random rdata c%0d: got %h expected %h", c, (rsp_port == 0 ? rsp_rdata_0 : rsp_rdata_1), rsp_data);
        end
      end
      rsp_port = -1;
      if (g >= 0) begin
        if (pwe[g]) ref_mem[pa[g]] = merge_mask(ref_mem[pa[g]], pd[g], pm[g]);
        else begin rsp_port = g; rsp_data = ref_mem[pa[g]]; end
        exp_rr = 1 - g;
        pv[g] = 1'b0;
      end
    end
    idle_inputs();
  endtask

  task automatic test_power;
    reset_dut();
    @(negedge clk);
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 14'h0777; req_wdata_0 = 16'h5A5A; req_mask_0 = 4'hF;
    #1;
    checks++; if (req_ready_0 !== 1'b1) begin errors++; $display("[TB] FAIL power write ready: got %b expected 1", req_ready_0); end
    // IDLE counted cycles, then the threshold cycle decides, so STANDBY shows on cycle IDLE+2.
    for (int i = 1; i <= IDLE + 2; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (ram_standby !== (i == IDLE + 2) || lp_state !== (i == IDLE + 2)) begin
        errors++; $display("[TB] FAIL power entry cycle %0d: got standby=%b lp=%b expected %b", i, ram_standby, lp_state, (i == IDLE + 2));
      end
    end
    for (int j = 0; j <= WAKE + 1; j++) begin
      @(negedge clk);
      req_valid_1 = 1'b1; req_we_1 = 1'b0; req_addr_1 = 14'h0777;
      #1;
      checks++; if (req_ready_1 !== (j == WAKE + 1) || ram_standby !== (j == 0) || lp_state !== (j <= WAKE)) begin
        errors++; $display("[TB] FAIL power wake step %0d: got ready=%b standby=%b lp=%b expected %b/%b/%b", j, req_ready_1, ram_standby, lp_state, (j == WAKE + 1), (j == 0), (j <= WAKE));
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rsp_valid_1 !== 1'b1 || rsp_rdata_1 !== 16'h5A5A) begin errors++; $display("[TB] FAIL power data intact: got v=%b d=%h expected 1/5a5a", rsp_valid_1, rsp_rdata_1); end
  endtask

  task automatic test_threshold;
    reset_dut();
    @(negedge clk);
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 14'h0888; req_wdata_0 = 16'h1357; req_mask_0 = 4'hF;
    for (int i = 1; i <= IDLE; i++) begin
      @(negedge clk);
      idle_inputs();
    end
    @(negedge clk);
    req_valid_0 = 1'b1; req_we_0 = 1'b0; req_addr_0 = 14'h0888;
    #1;
    checks++; if (req_ready_0 !== 1'b1 || ram_standby !== 1'b0) begin errors++; $display("[TB] FAIL threshold accept: got ready=%b standby=%b expected 1/0", req_ready_0, ram_standby); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (ram_standby !== 1'b0 || lp_state !== 1'b0) begin errors++; $display("[TB] FAIL threshold no standby %0d: got standby=%b lp=%b expected 0/0", i, ram_standby, lp_state); end
      if (i == 0) begin
        checks++; if (rsp_valid_0 !== 1'b1 || rsp_rdata_0 !== 16'h1357) begin errors++; $display("[TB] FAIL threshold rdata: got v=%b d=%h expected 1/1357", rsp_valid_0, rsp_rdata_0); end
      end
    end
  endtask

  task automatic test_reset_mid_read;
    reset_dut();
    @(negedge clk);
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 14'h0999; req_wdata_0 = 16'hC3C3; req_mask_0 = 4'hF;
    @(negedge clk);
    req_we_0 = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid_0 !== 1'b1 || rsp_rdata_0 !== 16'hC3C3 || req_ready_0 !== 1'b1) begin
      errors++; $display("[TB] FAIL midread back-to-back: got v=%b d=%h ready=%b expected 1/c3c3/1", rsp_valid_0, rsp_rdata_0, req_ready_0);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid_0 !== 1'b0) begin errors++; $display("[TB] FAIL midread rsp dropped: got %b expected 0", rsp_valid_0); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (rsp_valid_0 !== 1'b0 || rsp_rdata_0 !== 16'h0 || ram_cs !== 1'b0 || ram_standby !== 1'b0 || lp_state !== 1'b0) begin
      errors++; $display("[TB] FAIL midread after reset: got v=%b d=%h cs=%b standby=%b lp=%b expected 0/0000/0/0/0", rsp_valid_0, rsp_rdata_0, ram_cs, ram_standby, lp_state);
    end
    exp_rr = 0;
  endtask

  task automatic test_reset_standby;
    logic seen;
    reset_dut();
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (ram_standby === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL standby reached: got %b expected 1 within 60 cycles", seen); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ram_standby !== 1'b0 || lp_state !== 1'b0) begin errors++; $display("[TB] FAIL standby reset: got standby=%b lp=%b expected 0/0", ram_standby, lp_state); end
    @(negedge clk);
    req_valid_0 = 1'b1; req_we_0 = 1'b0; req_addr_0 = 14'h0001;
    #1;
    checks++; if (req_ready_0 !== 1'b1) begin errors++; $display("[TB] FAIL standby reset ready: got %b expected 1", req_ready_0); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    ram_dataout = '0;
    idle_inputs();
    test_reset();
    test_single_rw();
    test_mask();
    test_contention();
    test_random();
    test_power();
    test_threshold();
    test_reset_mid_read();
    test_reset_standby();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
